line_tap_buffer: RTL and testbench

Streaming multi-line buffer for the edge-detection pipeline. It accepts one pixel per clock in raster order and delays each pixel through TAPS-1 chained line memories of LINE_LEN pixels. On every accepted pixel it presents TAPS vertically aligned pixels from the same column, one per row, which feed the 3x3 (or larger) convolution window stage. It replaces the single-stream pixel FIFO with a block that is generalised in depth and tap count and is frame-aware.

---
 rtl/line_tap_buffer_pkg.sv | 17 +
 rtl/line_tap_buffer_line_ram.sv | 37 +++
 rtl/line_tap_buffer.sv | 117 +++++++++++
 tb/tb_line_tap_buffer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/line_tap_buffer_pkg.sv
// Shared constants and helpers for the line tap buffer.
package line_tap_pkg;

  localparam int LTB_WIDTH    = 8;
  localparam int LTB_LINE_LEN = 640;
  localparam int LTB_TAPS     = 3;

  function automatic int ltb_addr_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  // LSB position of tap slice k inside the packed taps bus
  function automatic int tap_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/line_tap_buffer_line_ram.sv
// Simple dual-port line memory: one write port, one synchronous read port
// returning the old contents on a same-address collision.
module line_ram
  import line_tap_pkg::*;
#(
  parameter int WIDTH = LTB_WIDTH,
  parameter int DEPTH = LTB_LINE_LEN,
  parameter int AW    = ltb_addr_w(LTB_LINE_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value while no pixel is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/line_tap_buffer.sv
// Streaming multi-line tap buffer presenting TAPS vertically aligned pixels.
// Optional LTB_BORDER_ZERO_EN: output from the sof pixel with zeroed top-border taps.
module line_tap_buffer
  import line_tap_pkg::*;
#(
  parameter int  WIDTH    = LTB_WIDTH,
  parameter int  LINE_LEN = LTB_LINE_LEN,
  parameter int  TAPS     = LTB_TAPS,
  localparam int ADDR_W   = ltb_addr_w(LINE_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  sof,
  input  logic [WIDTH-1:0]      din,
  output logic                  out_valid,
  output logic [TAPS*WIDTH-1:0] taps_out,
  output logic [ADDR_W-1:0]     out_col
);

  localparam int              RW       = 3;
  localparam logic [RW-1:0]   ROWS_MAX = RW'(TAPS - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_LEN - 1);

  logic [ADDR_W-1:0] col, cur_col, nxt_col, wr_addr_p;
  logic [RW-1:0]     rows, cur_rows, nxt_rows;
  logic [WIDTH-1:0]  din_q;
  logic              wr_en_p;
  logic [WIDTH-1:0]  ram_q [TAPS-1];
`ifdef LTB_BORDER_ZERO_EN
  logic [RW-1:0]     tap_rows;
  logic              started;
`endif

  // sof restarts the frame at column 0 / row 0 for the current pixel
  always_comb begin
    cur_col  = sof ? '0 : col;
    cur_rows = sof ? '0 : rows;
    if (cur_col == COL_LAST) begin
      nxt_col  = '0;
      nxt_rows = (cur_rows == ROWS_MAX) ? cur_rows : cur_rows + RW'(1);
    end else begin
      nxt_col  = cur_col + ADDR_W'(1);
      nxt_rows = cur_rows;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      rows      <= '0;
      out_valid <= 1'b0;
      out_col   <= '0;
      din_q     <= '0;
      wr_en_p   <= 1'b0;
      wr_addr_p <= '0;
    end else begin
      wr_en_p   <= in_valid;
      wr_addr_p <= cur_col;
      if (in_valid) begin
        col     <= nxt_col;
        rows    <= nxt_rows;
        out_col <= cur_col;
        din_q   <= din;
      end
`ifdef LTB_BORDER_ZERO_EN
      out_valid <= in_valid & (sof | started);
`else
      out_valid <= in_valid & (cur_rows == ROWS_MAX);
`endif
    end
  end

`ifdef LTB_BORDER_ZERO_EN
  // Frame tracking and the row depth used for border masking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_rows <= '0;
      started  <= 1'b0;
    end else if (in_valid) begin
      tap_rows <= cur_rows;
      started  <= started | sof;
    end
  end
`endif

  // RAM 0 takes the new pixel; each later RAM takes the previous RAM's
  // read data one cycle later, at the same column.
  for (genvar k = 0; k < TAPS - 1; k++) begin : g_ram
    if (k == 0) begin : g_first
      line_ram #(.WIDTH(WIDTH), .DEPTH(LINE_LEN), .AW(ADDR_W)) u_ram (
        .clk(clk), .rst(rst),
        .wr_en(in_valid), .wr_addr(cur_col), .wr_data(din),
        .rd_en(in_valid), .rd_addr(cur_col), .rd_data(ram_q[k])
      );
    end else begin : g_chain
      line_ram #(.WIDTH(WIDTH), .DEPTH(LINE_LEN), .AW(ADDR_W)) u_ram (
        .clk(clk), .rst(rst),
        .wr_en(wr_en_p), .wr_addr(wr_addr_p), .wr_data(ram_q[k-1]),
        .rd_en(in_valid), .rd_addr(cur_col), .rd_data(ram_q[k])
      );
    end
  end

  always_comb begin
    taps_out = '0;
    taps_out[tap_lsb(0, WIDTH) +: WIDTH] = din_q;
    for (int k = 1; k < TAPS; k++) begin
`ifdef LTB_BORDER_ZERO_EN
      taps_out[tap_lsb(k, WIDTH) +: WIDTH] = (RW'(k) > tap_rows) ? '0 : ram_q[k-1];
`else
      taps_out[tap_lsb(k, WIDTH) +: WIDTH] = ram_q[k-1];
`endif
    end
  end

endmodule

// File: tb/tb_line_tap_buffer.sv
// Self-checking bench for line_tap_buffer against a pixel-history model.
module tb_line_tap_buffer;

  localparam int W = 8;
  localparam int L = 4;
  localparam int T = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          sof;
  logic [W-1:0]  din;
  logic          out_valid;
  logic [T*W-1:0] taps_out;
  logic [1:0]    out_col;

  int tests;
  int fails;

  // reference model: all pixels accepted since frame start (or reset)
  logic [W-1:0]   hist [$];
  int             n;
  bit             framed;
  logic           exp_valid;
  logic [T*W-1:0] exp_taps;
  logic [1:0]     exp_col;
  bit             taps_known;

  line_tap_buffer #(.WIDTH(W), .LINE_LEN(L), .TAPS(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sof(sof), .din(din),
    .out_valid(out_valid), .taps_out(taps_out), .out_col(out_col)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    hist.delete();
    framed = 1'b0;
    exp_valid = 1'b0;
    exp_taps = '0;
    exp_col = 2'd0;
    taps_known = 1'b1;
  endtask

  task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
    int rows_m;
    int idx;
    @(negedge clk);
    in_valid = v;
    sof = s;
    din = d;
    if (v) begin
      if (s) begin
        n = 0;
        hist.delete();
        framed = 1'b1;
      end
      hist.push_back(d);
      rows_m = (n / L > T - 1) ? T - 1 : n / L;
      exp_col = 2'(n % L);
`ifdef LTB_BORDER_ZERO_EN
      exp_valid = framed;
      taps_known = 1'b1;
`else
      exp_valid = (n / L >= T - 1);
      taps_known = exp_valid;
`endif
      for (int k = 0; k < T; k++) begin
        if (k <= rows_m) begin
          idx = hist.size() - 1 - k * L;
          exp_taps[k*W +: W] = hist[idx];
        end else begin
          exp_taps[k*W +: W] = '0;
        end
      end
      n++;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("out_col", 32'(out_col), 32'(exp_col));
    if (taps_known) check("taps_out", 32'(taps_out), 32'(exp_taps));
    else check("tap0", 32'(taps_out[W-1:0]), 32'(exp_taps[W-1:0]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    sof = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_taps", 32'(taps_out), 32'd0);
    check("reset_col", 32'(out_col), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    sof = 1'b0;
    din = '0;
    model_reset();
    #12;
    check("init_valid", 32'(out_valid), 32'd0);
    check("init_taps", 32'(taps_out), 32'd0);
    check("init_col", 32'(out_col), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // fill: first full window after pixel 9
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, i == 1, W'(i));
`ifdef LTB_BORDER_ZERO_EN
      if (i == 1) check("border_p1", 32'(taps_out), 32'h000001);
      if (i == 5) check("border_p5", 32'(taps_out), 32'h000105);
`endif
      if (i == 9) check("fill_p9", 32'(taps_out), 32'h010509);
    end
    check("fill_p12", 32'(taps_out), 32'h04080C);
    check("fill_col", 32'(out_col), 32'd3);

    // same stream with random idle cycles
    for (int i = 1; i <= 12; i++) begin
      while ($urandom_range(0, 2) == 0) drive(1'b0, 1'b0, W'($urandom));
      drive(1'b1, i == 1, W'(i));
    end
    check("gap_p12", 32'(taps_out), 32'h04080C);

    // sof arriving mid-line
    for (int i = 1; i <= 6; i++) drive(1'b1, 1'b0, W'(200 + i));
    for (int i = 101; i <= 112; i++) begin
      drive(1'b1, i == 101, W'(i));
      if (i == 109) check("midsof_109", 32'(taps_out), {8'd0, 8'd101, 8'd105, 8'd109});
    end

    // five full lines, steady state
    for (int i = 1; i <= 20; i++) drive(1'b1, i == 1, W'(i));
    check("wrap_p20", 32'(taps_out), {8'd0, 8'd12, 8'd16, 8'd20});
    check("wrap_col", 32'(out_col), 32'd3);

    // random traffic with occasional restarts
    repeat (300) drive($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, W'($urandom));

    // reset mid-run, then refill without sof, then with sof
    do_reset();
    repeat (60) drive($urandom_range(0, 4) != 0, 1'b0, W'($urandom));
    repeat (150) drive($urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0, W'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
